mem_stage: RTL and testbench

Memory-access pipeline stage sitting directly downstream of the execute stage and upstream of write-back. Registers non-memory results through in one cycle; for loads and stores it runs a req/ack handshake with the data memory, stalls the upstream pipeline while waiting, and aborts on misalignment or timeout. Word-only access, 32-bit data.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_wdog.sv | 25 ++
 rtl/mem_stage.sv | 105 ++++++++++
 tb/tb_mem_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Word-only access: the two low address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] addr_lo);
    return (addr_lo == 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and data memory (slave).
interface mem_stage_if import mem_pkg::*; ();

  logic              MemReq;
  logic              MemWe;
  logic [DATA_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;
  logic              MemAck;

  modport master (
    output MemReq, MemWe, MemAddr, MemWData,
    input  MemRData, MemAck
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWData,
    output MemRData, MemAck
  );

endinterface

// File: rtl/mem_wdog.sv
// Watchdog counting wait cycles; expired flags the last permitted cycle.
module mem_wdog import mem_pkg::*; #(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Cycle counter, zeroed while clear is held, advancing while enabled.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: ALU pass-through, or load/store over a req/ack bus
// with upstream stall, misalignment rejection and timeout abort.
module mem_stage import mem_pkg::*; #(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] AddrIn,
  input  logic [DATA_W-1:0] StoreValIn,
  input  logic [REG_W-1:0]  DstIn,
  input  logic              WriteBackIn,
  input  logic              isMemRead,
  input  logic              isMemWrite,
  output logic              Stall,
  mem_stage_if.master       mem,
  output logic [DATA_W-1:0] Result,
  output logic [REG_W-1:0]  DstOut,
  output logic              WriteBack,
  output logic              MisalignErr,
  output logic              BusErr
);

  state_t            state;
  logic [REG_W-1:0]  cap_dst;
  logic              cap_wb;
  logic              cap_load;
  logic              is_mem;
  logic              expired;

  assign is_mem = isMemRead | isMemWrite;
  assign Stall  = (state == WAIT);

  mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (state == IDLE),
    .enable  (state == WAIT),
    .expired (expired)
  );

  // Stage FSM with registered bus and write-back outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      mem.MemReq   <= 1'b0;
      mem.MemWe    <= 1'b0;
      mem.MemAddr  <= '0;
      mem.MemWData <= '0;
      Result       <= '0;
      DstOut       <= '0;
      WriteBack    <= 1'b0;
      MisalignErr  <= 1'b0;
      BusErr       <= 1'b0;
      cap_dst      <= '0;
      cap_wb       <= 1'b0;
      cap_load     <= 1'b0;
    end else begin
      MisalignErr <= 1'b0;
      BusErr      <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_mem) begin
            Result    <= AddrIn;
            DstOut    <= DstIn;
            WriteBack <= WriteBackIn;
          end else if (!is_aligned(AddrIn[1:0])) begin
            WriteBack   <= 1'b0;
            MisalignErr <= 1'b1;
          end else begin
            mem.MemReq   <= 1'b1;
            mem.MemWe    <= isMemWrite;
            mem.MemAddr  <= AddrIn;
            mem.MemWData <= StoreValIn;
            cap_dst      <= DstIn;
            cap_wb       <= WriteBackIn;
            // read+write together behaves as a store
            cap_load     <= ~isMemWrite;
            WriteBack    <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (mem.MemAck) begin
            mem.MemReq <= 1'b0;
            if (cap_load) begin
              Result    <= mem.MemRData;
              DstOut    <= cap_dst;
              WriteBack <= cap_wb;
            end else begin
              WriteBack <= 1'b0;
            end
            state <= IDLE;
          end else if (expired) begin
            mem.MemReq <= 1'b0;
            WriteBack  <= 1'b0;
            BusErr     <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expectations, monitor retires them,
// a behavioural memory answers requests with per-op ack delays.
module tb_mem_stage;
  import mem_pkg::*;

  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] AddrIn, StoreValIn;
  logic [4:0]  DstIn;
  logic        WriteBackIn, isMemRead, isMemWrite;
  logic        Stall;
  logic [31:0] Result;
  logic [4:0]  DstOut;
  logic        WriteBack, MisalignErr, BusErr;
  logic        in_valid;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TO)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .AddrIn      (AddrIn),
    .StoreValIn  (StoreValIn),
    .DstIn       (DstIn),
    .WriteBackIn (WriteBackIn),
    .isMemRead   (isMemRead),
    .isMemWrite  (isMemWrite),
    .Stall       (Stall),
    .mem         (bus),
    .Result      (Result),
    .DstOut      (DstOut),
    .WriteBack   (WriteBack),
    .MisalignErr (MisalignErr),
    .BusErr      (BusErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dst;
    logic        wb, mis, berr, is_mem, we;
    logic [31:0] addr, wdata;
    int          stalls;
  } exp_t;

  typedef struct {
    int          delay;   // WAIT cycles before ack; 0 = never
    logic [31:0] rdata;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mem_q[$];

  int checks = 0;
  int failures = 0;
  logic [31:0] model_result = '0;
  logic [4:0]  model_dst = '0;
  int accepts = 0;
  int retired = 0;
  int stall_cnt = 0;
  bit done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Architectural model: outcome of one instruction from the stage's rules.
  task automatic issue(input logic [31:0] a, input logic [31:0] sv, input logic [4:0] d,
                       input logic wbi, input logic rd, input logic wr,
                       input int dly, input logic [31:0] rdat);
    exp_t  e;
    mreq_t m;
    AddrIn = a; StoreValIn = sv; DstIn = d; WriteBackIn = wbi;
    isMemRead = rd; isMemWrite = wr; in_valid = 1'b1;
    e.res = model_result; e.dst = model_dst;
    e.wb = 1'b0; e.mis = 1'b0; e.berr = 1'b0; e.stalls = 0;
    e.is_mem = rd | wr; e.we = wr; e.addr = a; e.wdata = sv;
    if (!(rd | wr)) begin
      e.res = a; e.dst = d; e.wb = wbi;
    end else if (a[1:0] != 2'b00) begin
      e.mis = 1'b1;
    end else begin
      m.delay = dly; m.rdata = rdat;
      mem_q.push_back(m);
      if (dly >= 1 && dly <= TO) begin
        e.stalls = dly;
        if (!wr) begin
          e.res = rdat; e.dst = d; e.wb = wbi;
        end
      end else begin
        e.stalls = TO; e.berr = 1'b1;
      end
    end
    model_result = e.res;
    model_dst    = e.dst;
    exp_q.push_back(e);
  endtask

  // Wait until the stage can accept again; inputs are garbage while stalled.
  task automatic wait_ready();
    int n = 0;
    @(negedge Clk);
    while (Stall && n < 40) begin
      AddrIn = $urandom; StoreValIn = $urandom; DstIn = 5'($urandom);
      WriteBackIn = 1'($urandom); isMemRead = 1'($urandom); isMemWrite = 1'($urandom);
      @(negedge Clk);
      n++;
    end
    chk("stall_bound", 32'(n < 40), 32'd1);
  endtask

  // Behavioural data memory.
  initial begin
    mreq_t cur;
    int j = 0;
    bit busy = 0;
    bus.MemAck = 1'b0;
    bus.MemRData = '0;
    cur.delay = 0; cur.rdata = '0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        busy = 0; bus.MemAck = 1'b0; mem_q.delete();
      end else if (bus.MemReq) begin
        if (!busy) begin
          if (mem_q.size() == 0) begin
            chk("unexpected_req", 32'(bus.MemReq), 32'd0);
            cur.delay = 1; cur.rdata = '0;
          end else begin
            cur = mem_q.pop_front();
          end
          busy = 1; j = 0;
        end
        j++;
        bus.MemAck   = (cur.delay != 0 && j == cur.delay);
        bus.MemRData = bus.MemAck ? cur.rdata : $urandom;
      end else begin
        busy = 0;
        bus.MemAck   = ($urandom_range(0, 7) == 0);
        bus.MemRData = $urandom;
      end
    end
  end

  // Count instructions taken by the stage.
  always @(posedge Clk) begin
    if (Reset && in_valid && !Stall) accepts++;
  end

  // Monitor: check bus while stalled, retire an expectation when the stage frees up.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      exp_q.delete(); retired = accepts; stall_cnt = 0;
    end else if (accepts != retired) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'(exp_q.size()), 32'd1);
        retired = accepts;
      end else if (Stall) begin
        e = exp_q[0];
        chk("req_held", 32'(bus.MemReq), 32'd1);
        chk("mem_we",   32'(bus.MemWe), 32'(e.we));
        chk("mem_addr", bus.MemAddr, e.addr);
        if (e.we) chk("mem_wdata", bus.MemWData, e.wdata);
        stall_cnt++;
      end else begin
        e = exp_q.pop_front();
        chk("result",    Result, e.res);
        chk("dst",       32'(DstOut), 32'(e.dst));
        chk("writeback", 32'(WriteBack), 32'(e.wb));
        chk("misalign",  32'(MisalignErr), 32'(e.mis));
        chk("buserr",    32'(BusErr), 32'(e.berr));
        chk("stalls",    32'(stall_cnt), 32'(e.stalls));
        chk("req_low",   32'(bus.MemReq), 32'd0);
        stall_cnt = 0;
        retired++;
      end
    end
  end

  initial begin
    #500000;
    if (!done) begin
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    int op;
    logic [31:0] a;
    Reset = 1'b0; in_valid = 1'b0;
    AddrIn = '0; StoreValIn = '0; DstIn = '0; WriteBackIn = 1'b0;
    isMemRead = 1'b0; isMemWrite = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_result", Result, 32'd0);
    chk("rst_dst",    32'(DstOut), 32'd0);
    chk("rst_wb",     32'(WriteBack), 32'd0);
    chk("rst_mis",    32'(MisalignErr), 32'd0);
    chk("rst_berr",   32'(BusErr), 32'd0);
    chk("rst_req",    32'(bus.MemReq), 32'd0);
    chk("rst_we",     32'(bus.MemWe), 32'd0);
    chk("rst_addr",   bus.MemAddr, 32'd0);
    chk("rst_wdata",  bus.MemWData, 32'd0);
    chk("rst_stall",  32'(Stall), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Directed cases
    issue(32'h1234, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 0, 32'h0);                 wait_ready();
    issue(32'h100, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3, 32'hDEADBEEF);           wait_ready();
    issue(32'h40, 32'hA5A5A5A5, 5'd9, 1'b1, 1'b0, 1'b1, 1, 32'h0);           wait_ready();
    issue(32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1, 32'h0);                  wait_ready();
    issue(32'h200, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 0, 32'h0);                  wait_ready();
    issue(32'h204, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, TO, 32'hCAFEF00D);         wait_ready();
    issue(32'h208, 32'h77, 5'd8, 1'b1, 1'b1, 1'b1, 2, 32'h12345678);         wait_ready();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 4));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue(a, $urandom, 5'($urandom), 1'($urandom),
            (op == 2 || op == 4), (op == 3 || op == 4),
            int'($urandom_range(0, TO + 1)), $urandom);
      wait_ready();
    end

    // Reset while a load is waiting
    issue(32'h300, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 0, 32'h0);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_req",    32'(bus.MemReq), 32'd0);
    chk("midrst_stall",  32'(Stall), 32'd0);
    chk("midrst_wb",     32'(WriteBack), 32'd0);
    chk("midrst_result", Result, 32'd0);
    chk("midrst_dst",    32'(DstOut), 32'd0);
    model_result = '0; model_dst = '0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    issue(32'h400, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 2, 32'h0BADF00D);         wait_ready();
    issue(32'h55AA, 32'h0, 5'd12, 1'b0, 1'b0, 1'b0, 0, 32'h0);               wait_ready();

    in_valid = 1'b0; isMemRead = 1'b0; isMemWrite = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
